// File: rtl/read_info_mc_pkg.sv
// Shared definitions for the multi-PU read-request tracker: data-type codes,
// router states and the log2 helper used to size derived widths.
package read_info_mc_pkg;

  localparam int DT_STREAM = 0;
  localparam int DT_BUFFER = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int c_log_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/read_info_mc_fifo.sv
// Outstanding-request FIFO with registered occupancy; full/empty derive from
// the registered count so they never depend on same-cycle push/pop.
module read_info_mc_fifo
  import read_info_mc_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [c_log_2(DEPTH):0]    count
);

  localparam int AW = c_log_2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage carries payload only; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/read_info_mc.sv
// Read-request tracker: queues {size, pu_id, d_type} and steers returning
// input-buffer words to the owning PU's stream or buffer port, one per cycle.
module read_info_mc
  import read_info_mc_pkg::*;
#(
  parameter int NUM_PU     = 4,
  parameter int D_TYPE_W   = 2,
  parameter int RD_SIZE_W  = 20,
  parameter int INFO_DEPTH = 8,
  parameter int PU_ID_W    = c_log_2(NUM_PU) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            rd_req,
  input  logic [RD_SIZE_W-1:0]            rd_req_size,
  input  logic [PU_ID_W-1:0]              rd_req_pu_id,
  input  logic [D_TYPE_W-1:0]             rd_req_d_type,
  output logic                            read_info_full,
  output logic                            rd_req_overflow,
  output logic [c_log_2(INFO_DEPTH):0]    outstanding,
  input  logic                            inbuf_empty,
  output logic                            inbuf_pop,
  input  logic [NUM_PU-1:0]               stream_full,
  input  logic [NUM_PU-1:0]               buffer_full,
  output logic [NUM_PU-1:0]               stream_push,
  output logic [NUM_PU-1:0]               buffer_push,
  output logic [PU_ID_W-1:0]              pu_id,
  output logic [D_TYPE_W-1:0]             d_type,
  output logic                            busy
);

  localparam int ENT_W = RD_SIZE_W + PU_ID_W + D_TYPE_W;

  state_t                 state;
  logic [RD_SIZE_W-1:0]   remaining;
  logic [ENT_W-1:0]       head;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [RD_SIZE_W-1:0]   head_size;
  logic [PU_ID_W-1:0]     head_pu;
  logic [D_TYPE_W-1:0]    head_dt;
  logic [NUM_PU-1:0]      pu_sel;
  logic                   is_stream;
  logic                   is_buffer;
  logic                   dest_full;
  logic                   last_word;

  assign fifo_push = rd_req && !read_info_full;

  read_info_mc_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (INFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   ({rd_req_size, rd_req_pu_id, rd_req_d_type}),
    .rdata   (head),
    .full    (read_info_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

  assign head_size = head[ENT_W-1 -: RD_SIZE_W];
  assign head_pu   = head[D_TYPE_W +: PU_ID_W];
  assign head_dt   = head[D_TYPE_W-1:0];

  // An out-of-range pu_id shifts the select to zero, so it behaves as discard.
  assign pu_sel    = NUM_PU'(1) << pu_id;
  assign is_stream = (d_type == D_TYPE_W'(DT_STREAM));
  assign is_buffer = (d_type == D_TYPE_W'(DT_BUFFER));
  assign dest_full = (is_stream && |(stream_full & pu_sel)) ||
                     (is_buffer && |(buffer_full & pu_sel));

  assign busy        = (state == ST_XFER);
  assign inbuf_pop   = busy && !inbuf_empty && !dest_full;
  assign stream_push = (inbuf_pop && is_stream) ? pu_sel : '0;
  assign buffer_push = (inbuf_pop && is_buffer) ? pu_sel : '0;
  assign last_word   = inbuf_pop && (remaining == RD_SIZE_W'(1));

  // Reload on the last word keeps back-to-back requests bubble-free.
  assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || last_word);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      remaining       <= '0;
      pu_id           <= '0;
      d_type          <= '0;
      rd_req_overflow <= 1'b0;
    end else begin
      if (rd_req && read_info_full) rd_req_overflow <= 1'b1;
      if (fifo_pop) begin
        pu_id     <= head_pu;
        d_type    <= head_dt;
        remaining <= head_size;
        state     <= (head_size != '0) ? ST_XFER : ST_IDLE;
      end else if (inbuf_pop) begin
        remaining <= remaining - 1'b1;
        if (last_word) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_read_info_mc.sv
// Scoreboard bench for read_info_mc: directed scenarios plus randomized
// requests and back-pressure against a word-level reference queue.
module tb_read_info_mc;

  localparam int NUM_PU     = 4;
  localparam int D_TYPE_W   = 2;
  localparam int RD_SIZE_W  = 20;
  localparam int INFO_DEPTH = 8;
  localparam int PU_ID_W    = 3;
  localparam int CNT_W      = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   rd_req;
  logic [RD_SIZE_W-1:0]   rd_req_size;
  logic [PU_ID_W-1:0]     rd_req_pu_id;
  logic [D_TYPE_W-1:0]    rd_req_d_type;
  logic                   read_info_full;
  logic                   rd_req_overflow;
  logic [CNT_W-1:0]       outstanding;
  logic                   inbuf_empty;
  logic                   inbuf_pop;
  logic [NUM_PU-1:0]      stream_full;
  logic [NUM_PU-1:0]      buffer_full;
  logic [NUM_PU-1:0]      stream_push;
  logic [NUM_PU-1:0]      buffer_push;
  logic [PU_ID_W-1:0]     pu_id;
  logic [D_TYPE_W-1:0]    d_type;
  logic                   busy;

  read_info_mc #(
    .NUM_PU     (NUM_PU),
    .D_TYPE_W   (D_TYPE_W),
    .RD_SIZE_W  (RD_SIZE_W),
    .INFO_DEPTH (INFO_DEPTH),
    .PU_ID_W    (PU_ID_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rd_req          (rd_req),
    .rd_req_size     (rd_req_size),
    .rd_req_pu_id    (rd_req_pu_id),
    .rd_req_d_type   (rd_req_d_type),
    .read_info_full  (read_info_full),
    .rd_req_overflow (rd_req_overflow),
    .outstanding     (outstanding),
    .inbuf_empty     (inbuf_empty),
    .inbuf_pop       (inbuf_pop),
    .stream_full     (stream_full),
    .buffer_full     (buffer_full),
    .stream_push     (stream_push),
    .buffer_push     (buffer_push),
    .pu_id           (pu_id),
    .d_type          (d_type),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pu;
    int dt;
  } word_t;

  word_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    pop_cnt, run_len, max_run;
  int    sp_cnt[NUM_PU];
  int    bp_cnt[NUM_PU];
  bit    rnd_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: where a single word of a request must land.
  function automatic logic [NUM_PU-1:0] exp_sp(input int pu, input int dt);
    return (pu < NUM_PU && dt == 0) ? NUM_PU'(1) << pu : '0;
  endfunction

  function automatic logic [NUM_PU-1:0] exp_bp(input int pu, input int dt);
    return (pu < NUM_PU && dt == 1) ? NUM_PU'(1) << pu : '0;
  endfunction

  function automatic bit dest_blocked(input int pu, input int dt);
    if (pu >= NUM_PU) return 1'b0;
    if (dt == 0) return stream_full[pu];
    if (dt == 1) return buffer_full[pu];
    return 1'b0;
  endfunction

  task automatic clear_tally();
    pop_cnt = 0; run_len = 0; max_run = 0;
    for (int i = 0; i < NUM_PU; i++) begin
      sp_cnt[i] = 0; bp_cnt[i] = 0;
    end
  endtask

  // Monitor: every popped word must match the head of the reference queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (inbuf_pop === 1'b1) begin
        pop_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        for (int i = 0; i < NUM_PU; i++) begin
          sp_cnt[i] += int'(stream_push[i]);
          bp_cnt[i] += int'(buffer_push[i]);
        end
        if (sb.size() == 0) begin
          check("pop_without_request", 64'(inbuf_pop), 64'd0);
        end else begin
          word_t e;
          e = sb.pop_front();
          check("stream_push", 64'(stream_push), 64'(exp_sp(e.pu, e.dt)));
          check("buffer_push", 64'(buffer_push), 64'(exp_bp(e.pu, e.dt)));
          check("pop_into_full_dest", 64'(inbuf_pop && dest_blocked(e.pu, e.dt)), 64'd0);
        end
      end else begin
        run_len = 0;
        check("push_without_pop", 64'({stream_push, buffer_push}), 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      inbuf_empty = ($urandom_range(3, 0) == 0);
      stream_full = NUM_PU'($urandom) & NUM_PU'($urandom);
      buffer_full = NUM_PU'($urandom) & NUM_PU'($urandom);
    end
  endtask

  task automatic send(input int size, input int pu, input int dt, input bit accept);
    rd_req        = 1'b1;
    rd_req_size   = RD_SIZE_W'(size);
    rd_req_pu_id  = PU_ID_W'(pu);
    rd_req_d_type = D_TYPE_W'(dt);
    if (accept) begin
      for (int k = 0; k < size; k++) sb.push_back('{pu: pu, dt: dt});
    end
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy || outstanding != '0) && k < budget) begin
      cyc();
      k++;
    end
    check({name, "_words_left"}, 64'(sb.size()), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_outstanding_after"}, 64'(outstanding), 64'd0);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k;
    k = 0;
    while (pop_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_pops", 64'(pop_cnt), 64'(target));
  endtask

  initial begin
    int sum;
    reset_n = 1'b0; rd_req = 1'b0; rd_req_size = '0; rd_req_pu_id = '0;
    rd_req_d_type = '0; inbuf_empty = 1'b1; stream_full = '0; buffer_full = '0;
    clear_tally();
    repeat (3) cyc();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_full", 64'(read_info_full), 64'd0);
    check("rst_overflow", 64'(rd_req_overflow), 64'd0);
    check("rst_outputs", 64'({inbuf_pop, stream_push, buffer_push, pu_id, d_type}), 64'd0);
    reset_n = 1'b1;
    cyc();

    // Basic stream transfer to PU 2.
    clear_tally();
    inbuf_empty = 1'b0;
    send(4, 2, 0, 1'b1);
    drain("basic", 50);
    check("basic_pops", 64'(pop_cnt), 64'd4);
    check("basic_stream_pu2", 64'(sp_cnt[2]), 64'd4);
    check("basic_run", 64'(max_run), 64'd4);
    check("basic_latched_pu", 64'(pu_id), 64'd2);

    // Buffer back-pressure on word 2.
    clear_tally();
    send(3, 1, 1, 1'b1);
    wait_pops(1, 20);
    @(posedge clk); #1;
    buffer_full[1] = 1'b1;
    repeat (5) cyc();
    check("bp_stalled_pops", 64'(pop_cnt), 64'd1);
    check("bp_busy_in_stall", 64'(busy), 64'd1);
    buffer_full[1] = 1'b0;
    drain("bp", 50);
    sum = 0;
    for (int i = 0; i < NUM_PU; i++) sum += sp_cnt[i] + (i == 1 ? 0 : bp_cnt[i]);
    check("bp_buffer_pu1", 64'(bp_cnt[1]), 64'd3);
    check("bp_other_pushes", 64'(sum), 64'd0);

    // Back-to-back requests queued before data arrives.
    inbuf_empty = 1'b1;
    send(2, 0, 0, 1'b1);
    send(3, 3, 1, 1'b1);
    repeat (2) cyc();
    clear_tally();
    inbuf_empty = 1'b0;
    drain("b2b", 50);
    check("b2b_pops", 64'(pop_cnt), 64'd5);
    check("b2b_no_bubble", 64'(max_run), 64'd5);
    check("b2b_stream_pu0", 64'(sp_cnt[0]), 64'd2);
    check("b2b_buffer_pu3", 64'(bp_cnt[3]), 64'd3);

    // Zero-size entry followed by a discard-type request.
    clear_tally();
    send(0, 1, 0, 1'b1);
    send(2, 1, 2, 1'b1);
    drain("discard", 50);
    sum = 0;
    for (int i = 0; i < NUM_PU; i++) sum += sp_cnt[i] + bp_cnt[i];
    check("discard_pops", 64'(pop_cnt), 64'd2);
    check("discard_pushes", 64'(sum), 64'd0);

    // Fill the queue with no data; the first request sits in the router.
    inbuf_empty = 1'b1;
    for (int i = 0; i < 9; i++) send(1, i % NUM_PU, i % 2, 1'b1);
    check("ovf_full", 64'(read_info_full), 64'd1);
    check("ovf_outstanding", 64'(outstanding), 64'd8);
    check("ovf_flag_clear", 64'(rd_req_overflow), 64'd0);
    // Enqueue while the router dequeues: registered full drops it.
    inbuf_empty = 1'b0;
    send(5, 2, 0, 1'b0);
    check("ovf_flag_set", 64'(rd_req_overflow), 64'd1);
    check("ovf_after_deq", 64'(outstanding), 64'd7);
    drain("ovf", 80);
    check("ovf_flag_sticky", 64'(rd_req_overflow), 64'd1);

    // Asynchronous reset in the middle of a long transfer.
    clear_tally();
    send(10, 0, 0, 1'b1);
    wait_pops(3, 20);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_outputs", 64'({inbuf_pop, stream_push, buffer_push, pu_id, d_type}), 64'd0);
    check("arst_outstanding", 64'(outstanding), 64'd0);
    check("arst_overflow", 64'(rd_req_overflow), 64'd0);
    sb.delete();
    repeat (2) cyc();
    reset_n = 1'b1;
    clear_tally();
    repeat (10) cyc();
    check("arst_no_pops_after", 64'(pop_cnt), 64'd0);

    // Randomized batches with random back-pressure and inbuf gaps.
    rnd_mode = 1'b1;
    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(5, 1);
      for (int r = 0; r < n; r++) begin
        send($urandom_range(6, 0), $urandom_range(7, 0), $urandom_range(3, 0), 1'b1);
        if ($urandom_range(1, 0) == 1) cyc();
      end
      drain("rand", 600);
    end
    rnd_mode = 1'b0;
    inbuf_empty = 1'b1; stream_full = '0; buffer_full = '0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
